// File: rtl/mod_cntr_gen.sv
// mod_cntr_gen: parametrised modulo-MODULUS up/down counter.
//   - Counts 0..MODULUS-1 with enable and direction.
//   - Synchronous load with range check; out-of-range loads raise load_err.
//   - wrap pulses for one cycle when the count crosses the modulo boundary.
//   - Synchronous, active-high reset_ loads INIT.
// Optional build macro: MOD_CNTR_FORMAL_EN embeds invariant properties and
// covers. Without it the module has no properties and behaves identically.
module mod_cntr_gen #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10,
    parameter int unsigned INIT    = 0
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap,
    output logic             load_err,
    output logic             at_term
);

    // All arithmetic is done one bit wider than the counter so that
    // MODULUS == 2**WIDTH is representable and no wrap relies on overflow.
    localparam logic [WIDTH:0] MOD_EXT  = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] TOP_EXT  = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] INIT_EXT = (WIDTH+1)'(INIT);
    localparam logic [WIDTH:0] ONE_EXT  = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] ZERO_EXT = (WIDTH+1)'(0);

    // The state register carries the extra bit too; it is always zero
    // because every value written into it is below MODULUS.
    logic [WIDTH:0] cnt_q;
    logic [WIDTH:0] cnt_d;
    logic           wrap_q;
    logic           wrap_d;
    logic           load_err_q;
    logic           load_err_d;
    logic [WIDTH:0] load_ext_s;

    assign load_ext_s = {1'b0, load_val};

    // Next-state: load beats count beats hold; load_val is only looked at when load=1.
    always_comb begin
        cnt_d      = cnt_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            if (load_ext_s < MOD_EXT) begin
                cnt_d = load_ext_s;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (en) begin
            if (up) begin
                if (cnt_q == TOP_EXT) begin
                    cnt_d  = ZERO_EXT;
                    wrap_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE_EXT;
                end
            end else begin
                if (cnt_q == ZERO_EXT) begin
                    cnt_d  = TOP_EXT;
                    wrap_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - ONE_EXT;
                end
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State register with synchronous reset to INIT; reset overrides load and en.
    always_ff @(posedge clk) begin
        if (reset_) begin
            cnt_q      <= INIT_EXT;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    // Terminal-count flag follows the current direction, so it is combinational.
    always_comb begin
        at_term = 1'b0;
        if (up) begin
            at_term = (cnt_q == TOP_EXT);
        end else begin
            at_term = (cnt_q == ZERO_EXT);
        end
    end

    assign cnt      = cnt_q[WIDTH-1:0];
    assign wrap     = wrap_q;
    assign load_err = load_err_q;

`ifdef MOD_CNTR_FORMAL_EN
    logic formal_valid_r = 1'b0;

    // Marks that at least one clock edge has elapsed since the initial state.
    always_ff @(posedge clk) begin
        formal_valid_r <= 1'b1;
    end

    // Count never leaves the legal range.
    a_cnt_range: assert property (@(posedge clk) disable iff (!formal_valid_r || reset_)
        cnt_q < MOD_EXT);

    // A wrap can only follow an enabled, non-load cycle sitting on the terminal value.
    a_wrap_cause: assert property (@(posedge clk) disable iff (!formal_valid_r || reset_)
        wrap_q |-> $past(en && !load && at_term));

    // A rejected load can only follow an out-of-range load request.
    a_err_cause: assert property (@(posedge clk) disable iff (!formal_valid_r || reset_)
        load_err_q |-> $past(load && (load_ext_s >= MOD_EXT)));

    // Wrap and rejected load are mutually exclusive.
    a_excl: assert property (@(posedge clk) disable iff (!formal_valid_r || reset_)
        !(wrap_q && load_err_q));

    // The first cycle after reset shows INIT.
    a_init: assert property (@(posedge clk) disable iff (!formal_valid_r || reset_)
        $past(reset_) |-> (cnt_q == INIT_EXT));

    c_up_wrap:   cover property (@(posedge clk) disable iff (reset_) wrap_q && cnt_q == ZERO_EXT);
    c_down_wrap: cover property (@(posedge clk) disable iff (reset_) wrap_q && cnt_q == TOP_EXT);
    c_load_err:  cover property (@(posedge clk) disable iff (reset_) load_err_q);
`endif

endmodule

// File: tb/tb_mod_cntr_gen.sv
// Self-checking bench for mod_cntr_gen. Four instances cover the
// configurations of interest; a vector table drives one instance per cycle
// while the others idle, followed by a few hand-written sequences.
module tb_mod_cntr_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Per-instance stimulus; index 0: W2/M3/I0, 1: W4/M10/I0, 2: W4/M16/I0, 3: W4/M10/I3
    logic       rst_a  [4];
    logic       en_a   [4];
    logic       up_a   [4];
    logic       ld_a   [4];
    logic [3:0] lv_a   [4];
    logic       wrap_a [4];
    logic       err_a  [4];
    logic       term_a [4];
    logic [1:0] cnt0;
    logic [3:0] cnt1, cnt2, cnt3;

    int unsigned mods  [4] = '{3, 10, 16, 10};
    int unsigned inits [4] = '{0, 0, 0, 3};

    mod_cntr_gen #(.WIDTH(2), .MODULUS(3), .INIT(0)) u0 (
        .clk(clk), .reset_(rst_a[0]), .en(en_a[0]), .up(up_a[0]), .load(ld_a[0]),
        .load_val(lv_a[0][1:0]), .cnt(cnt0), .wrap(wrap_a[0]), .load_err(err_a[0]),
        .at_term(term_a[0]));
    mod_cntr_gen #(.WIDTH(4), .MODULUS(10), .INIT(0)) u1 (
        .clk(clk), .reset_(rst_a[1]), .en(en_a[1]), .up(up_a[1]), .load(ld_a[1]),
        .load_val(lv_a[1]), .cnt(cnt1), .wrap(wrap_a[1]), .load_err(err_a[1]),
        .at_term(term_a[1]));
    mod_cntr_gen #(.WIDTH(4), .MODULUS(16), .INIT(0)) u2 (
        .clk(clk), .reset_(rst_a[2]), .en(en_a[2]), .up(up_a[2]), .load(ld_a[2]),
        .load_val(lv_a[2]), .cnt(cnt2), .wrap(wrap_a[2]), .load_err(err_a[2]),
        .at_term(term_a[2]));
    mod_cntr_gen #(.WIDTH(4), .MODULUS(10), .INIT(3)) u3 (
        .clk(clk), .reset_(rst_a[3]), .en(en_a[3]), .up(up_a[3]), .load(ld_a[3]),
        .load_val(lv_a[3]), .cnt(cnt3), .wrap(wrap_a[3]), .load_err(err_a[3]),
        .at_term(term_a[3]));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         dut;
        logic       rst;
        logic       en;
        logic       up;
        logic       ld;
        logic [3:0] lv;
        logic [3:0] cnt;
        logic       wrap;
        logic       err;
        string      name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int d, logic r, logic e, logic u, logic l,
                                logic [3:0] lv, logic [3:0] c, logic w, logic er,
                                string n);
        vec_t v;
        v.dut = d; v.rst = r; v.en = e; v.up = u; v.ld = l;
        v.lv = lv; v.cnt = c; v.wrap = w; v.err = er; v.name = n;
        return v;
    endfunction

    function automatic logic [3:0] get_cnt(int d);
        case (d)
            0: return {2'b00, cnt0};
            1: return cnt1;
            2: return cnt2;
            default: return cnt3;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_all();
        for (int j = 0; j < 4; j++) begin
            rst_a[j] = 1'b0; en_a[j] = 1'b0; up_a[j] = 1'b1;
            ld_a[j] = 1'b0; lv_a[j] = 4'd0;
        end
    endtask

    // Drive one vector, clock it, and check cnt/wrap/load_err/at_term.
    task automatic apply(vec_t v, int idx);
        logic exp_term;
        idle_all();
        rst_a[v.dut] = v.rst; en_a[v.dut] = v.en; up_a[v.dut] = v.up;
        ld_a[v.dut] = v.ld;   lv_a[v.dut] = v.lv;
        @(posedge clk);
        #1;
        exp_term = v.up ? (32'(v.cnt) == mods[v.dut] - 1) : (v.cnt == 4'd0);
        chk($sformatf("%s[%0d] cnt", v.name, idx), 32'(get_cnt(v.dut)), 32'(v.cnt));
        chk($sformatf("%s[%0d] wrap", v.name, idx), 32'(wrap_a[v.dut]), 32'(v.wrap));
        chk($sformatf("%s[%0d] load_err", v.name, idx), 32'(err_a[v.dut]), 32'(v.err));
        chk($sformatf("%s[%0d] at_term", v.name, idx), 32'(term_a[v.dut]), 32'(exp_term));
    endtask

    int   m;
    logic mw, me;
    logic r_en, r_up, r_ld;
    logic [3:0] r_lv;

    initial begin
        // ---------------- table ----------------
        // mod-3 up count: 1,2,0,1,2,0,1 with wrap on the zeros
        vecs.push_back(mk(0, 0, 1, 1, 0, 4'd0, 4'd1, 0, 0, "m3_up"));
        vecs.push_back(mk(0, 0, 1, 1, 0, 4'd0, 4'd2, 0, 0, "m3_up"));
        vecs.push_back(mk(0, 0, 1, 1, 0, 4'd0, 4'd0, 1, 0, "m3_up"));
        vecs.push_back(mk(0, 0, 1, 1, 0, 4'd0, 4'd1, 0, 0, "m3_up"));
        vecs.push_back(mk(0, 0, 1, 1, 0, 4'd0, 4'd2, 0, 0, "m3_up"));
        vecs.push_back(mk(0, 0, 1, 1, 0, 4'd0, 4'd0, 1, 0, "m3_up"));
        vecs.push_back(mk(0, 0, 1, 1, 0, 4'd0, 4'd1, 0, 0, "m3_up"));
        vecs.push_back(mk(0, 0, 0, 1, 0, 4'd0, 4'd1, 0, 0, "m3_hold"));
        vecs.push_back(mk(0, 0, 1, 0, 0, 4'd0, 4'd0, 0, 0, "m3_dn"));
        vecs.push_back(mk(0, 0, 1, 0, 0, 4'd0, 4'd2, 1, 0, "m3_dnwrap"));
        vecs.push_back(mk(0, 0, 1, 1, 0, 4'd0, 4'd0, 1, 0, "m3_dirchg"));
        vecs.push_back(mk(0, 0, 1, 1, 1, 4'd3, 4'd0, 0, 1, "m3_badload"));
        // mod-10: load 5 then count down through the wrap
        vecs.push_back(mk(1, 0, 0, 0, 1, 4'd5, 4'd5, 0, 0, "m10_load"));
        vecs.push_back(mk(1, 0, 1, 0, 0, 4'd0, 4'd4, 0, 0, "m10_dn"));
        vecs.push_back(mk(1, 0, 1, 0, 0, 4'd0, 4'd3, 0, 0, "m10_dn"));
        vecs.push_back(mk(1, 0, 1, 0, 0, 4'd0, 4'd2, 0, 0, "m10_dn"));
        vecs.push_back(mk(1, 0, 1, 0, 0, 4'd0, 4'd1, 0, 0, "m10_dn"));
        vecs.push_back(mk(1, 0, 1, 0, 0, 4'd0, 4'd0, 0, 0, "m10_dn"));
        vecs.push_back(mk(1, 0, 1, 0, 0, 4'd0, 4'd9, 1, 0, "m10_dn"));
        vecs.push_back(mk(1, 0, 1, 0, 0, 4'd0, 4'd8, 0, 0, "m10_dn"));
        // rejected load ignores en, next enabled cycle counts on
        vecs.push_back(mk(1, 0, 0, 1, 1, 4'd4, 4'd4, 0, 0, "m10_load4"));
        vecs.push_back(mk(1, 0, 1, 1, 1, 4'd12, 4'd4, 0, 1, "m10_rej12"));
        vecs.push_back(mk(1, 0, 1, 1, 0, 4'd0, 4'd5, 0, 0, "m10_after"));
        vecs.push_back(mk(1, 0, 0, 1, 1, 4'd10, 4'd5, 0, 1, "m10_rej10"));
        vecs.push_back(mk(1, 0, 0, 1, 1, 4'd9, 4'd9, 0, 0, "m10_load9"));
        vecs.push_back(mk(1, 0, 0, 1, 0, 4'd0, 4'd9, 0, 0, "m10_hold"));
        vecs.push_back(mk(1, 0, 1, 1, 0, 4'd0, 4'd0, 1, 0, "m10_upwrap"));
        vecs.push_back(mk(1, 0, 1, 1, 1, 4'd15, 4'd0, 0, 1, "m10_rej15"));
        vecs.push_back(mk(1, 0, 0, 1, 0, 4'd0, 4'd0, 0, 0, "m10_hold2"));
        // full-range modulus 16
        vecs.push_back(mk(2, 0, 0, 1, 1, 4'd15, 4'd15, 0, 0, "m16_load"));
        vecs.push_back(mk(2, 0, 1, 1, 0, 4'd0, 4'd0, 1, 0, "m16_upwrap"));
        vecs.push_back(mk(2, 0, 1, 0, 0, 4'd0, 4'd15, 1, 0, "m16_dnwrap"));
        vecs.push_back(mk(2, 0, 1, 0, 0, 4'd0, 4'd14, 0, 0, "m16_dn"));
        vecs.push_back(mk(2, 0, 0, 1, 1, 4'd0, 4'd0, 0, 0, "m16_load0"));
        // INIT=3: reset overrides load and en
        vecs.push_back(mk(3, 0, 0, 1, 1, 4'd6, 4'd6, 0, 0, "i3_load"));
        vecs.push_back(mk(3, 0, 1, 1, 0, 4'd0, 4'd7, 0, 0, "i3_up"));
        vecs.push_back(mk(3, 1, 1, 1, 1, 4'd2, 4'd3, 0, 0, "i3_rstload"));
        vecs.push_back(mk(3, 0, 1, 1, 0, 4'd0, 4'd4, 0, 0, "i3_up2"));
        vecs.push_back(mk(3, 0, 0, 1, 1, 4'd9, 4'd9, 0, 0, "i3_load9"));
        vecs.push_back(mk(3, 1, 1, 1, 0, 4'd0, 4'd3, 0, 0, "i3_rstwrap"));
        vecs.push_back(mk(3, 0, 1, 0, 0, 4'd0, 4'd2, 0, 0, "i3_dn"));

        // ---------------- reset state ----------------
        idle_all();
        for (int j = 0; j < 4; j++) rst_a[j] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("reset%0d cnt", j), 32'(get_cnt(j)), inits[j]);
            chk($sformatf("reset%0d wrap", j), 32'(wrap_a[j]), 32'd0);
            chk($sformatf("reset%0d load_err", j), 32'(err_a[j]), 32'd0);
        end

        // ---------------- table run ----------------
        foreach (vecs[i]) apply(vecs[i], i);

        // ---------------- load_val ignored when load=0 ----------------
        idle_all();
        ld_a[1] = 1'b1; lv_a[1] = 4'd7;
        @(posedge clk); #1;
        chk("xprop_setup cnt", 32'(cnt1), 32'd7);
        ld_a[1] = 1'b0; lv_a[1] = 4'bxxxx; en_a[1] = 1'b1; up_a[1] = 1'b1;
        @(posedge clk); #1;
        chk("xprop known", 32'($isunknown(cnt1)), 32'd0);
        chk("xprop cnt", 32'(cnt1), 32'd8);

        // ---------------- wrap is a single-cycle pulse ----------------
        idle_all();
        ld_a[0] = 1'b1; lv_a[0] = 4'd2;
        @(posedge clk); #1;
        idle_all();
        en_a[0] = 1'b1; up_a[0] = 1'b1;
        @(posedge clk); #1;
        chk("pulse wrap1", 32'(wrap_a[0]), 32'd1);
        en_a[0] = 1'b0;
        @(posedge clk); #1;
        chk("pulse wrap0", 32'(wrap_a[0]), 32'd0);
        chk("pulse cnt", 32'(cnt0), 32'd0);

        // ---------------- random walk on mod-10 against a reference model ----------------
        idle_all();
        ld_a[1] = 1'b1; lv_a[1] = 4'd0;
        @(posedge clk); #1;
        m = 0;
        chk("walk start", 32'(cnt1), 32'd0);
        for (int k = 0; k < 60; k++) begin
            r_ld = ($urandom_range(0, 5) == 0);
            r_en = ($urandom_range(0, 3) != 0);
            r_up = $urandom_range(0, 1) != 0;
            r_lv = 4'($urandom_range(0, 15));
            idle_all();
            en_a[1] = r_en; up_a[1] = r_up; ld_a[1] = r_ld; lv_a[1] = r_lv;
            mw = 1'b0; me = 1'b0;
            if (r_ld) begin
                if (int'(r_lv) < 10) m = int'(r_lv);
                else me = 1'b1;
            end else if (r_en) begin
                if (r_up) begin
                    if (m == 9) begin m = 0; mw = 1'b1; end
                    else m = m + 1;
                end else begin
                    if (m == 0) begin m = 9; mw = 1'b1; end
                    else m = m - 1;
                end
            end
            @(posedge clk); #1;
            chk($sformatf("walk[%0d] cnt", k), 32'(cnt1), 32'(m));
            chk($sformatf("walk[%0d] wrap", k), 32'(wrap_a[1]), 32'(mw));
            chk($sformatf("walk[%0d] load_err", k), 32'(err_a[1]), 32'(me));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
